// File: rtl/bop_input_encoder_pkg.sv
// Shared bop-it command code space, used by both the input encoder and the game block.
package bop_pkg;

  localparam int CODE_W  = 4;
  localparam int NUM_BTN = 4;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_SW0   = 4'd0;
  localparam code_t CODE_SW1   = 4'd1;
  localparam code_t CODE_SW2   = 4'd2;
  localparam code_t CODE_SW3   = 4'd3;
  localparam code_t CODE_SW4   = 4'd4;
  localparam code_t CODE_SW5   = 4'd5;
  localparam code_t CODE_SW6   = 4'd6;
  localparam code_t CODE_SW7   = 4'd7;
  localparam code_t CODE_BTN_U = 4'd8;
  localparam code_t CODE_BTN_R = 4'd9;
  localparam code_t CODE_BTN_D = 4'd10;
  localparam code_t CODE_BTN_L = 4'd11;
  localparam code_t CODE_NONE  = 4'd15;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // Lowest set bit index wins; bit position equals command code.
  function automatic code_t lowest_code(input logic [11:0] evt);
    code_t c;
    c = CODE_NONE;
    for (int i = 11; i >= 0; i--) begin
      c = evt[i] ? code_t'(i) : c;
    end
    return c;
  endfunction

  function automatic logic is_multi(input logic [11:0] evt);
    return |(evt & (evt - 12'd1));
  endfunction

endpackage

// File: rtl/bop_input_encoder_debounce.sv
// One input channel: 2-flop synchroniser, stability counter, debounced level and edge pulse.
module bop_debounce #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic FALL_EN         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_event
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_cnt    <= {CW{1'b0}};
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s2 == r_stable) begin
        r_cnt <= {CW{1'b0}};
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_s2;
        r_cnt    <= {CW{1'b0}};
        r_rise   <= r_s2;
        r_fall   <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_level = r_stable;
  assign o_event = r_rise | (r_fall & FALL_EN);

endmodule

// File: rtl/bop_input_encoder.sv
// Bop-it player input encoder: debounced switches/buttons -> valid/ready action codes.
// Optional macro BOP_SW_BOTH_EDGES_EN: switch falls also count as actions.
module bop_input_encoder
  import bop_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_SW          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw,
  input  logic              btnU,
  input  logic              btnR,
  input  logic              btnD,
  input  logic              btnL,
  output logic              act_valid,
  output logic [CODE_W-1:0] act_code,
  output logic              act_multi,
  input  logic              act_ready,
  output logic              overrun,
  output logic [NUM_SW-1:0] sw_level
);

  localparam int NUM_IN = NUM_SW + NUM_BTN;
  // Mask spans the full sync + debounce settle of a level already present at release.
  localparam int MASK_CW = $clog2(DEBOUNCE_CYCLES + 4);
  localparam logic [MASK_CW-1:0] MASK_END = MASK_CW'(DEBOUNCE_CYCLES + 3);

`ifdef BOP_SW_BOTH_EDGES_EN
  localparam logic SW_FALL_EN = 1'b1;
`else
  localparam logic SW_FALL_EN = 1'b0;
`endif

  logic [NUM_IN-1:0]  w_raw;
  logic [NUM_IN-1:0]  w_level;
  logic [NUM_IN-1:0]  w_evt_raw;
  logic [11:0]        w_evt;
  logic               w_any;
  code_t              w_code;
  logic               w_multi;
  logic [MASK_CW-1:0] r_mask_cnt;
  state_t             r_state;

  assign w_raw = {btnL, btnD, btnR, btnU, sw};

  for (genvar g = 0; g < NUM_IN; g++) begin : g_db
    bop_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .FALL_EN        ((g < NUM_SW) ? SW_FALL_EN : 1'b0)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (w_raw[g]),
      .o_level(w_level[g]),
      .o_event(w_evt_raw[g])
    );
  end

  assign sw_level = w_level[NUM_SW-1:0];

  // Post-reset startup mask counter, saturating at MASK_END.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask_cnt <= {MASK_CW{1'b0}};
    end else if (r_mask_cnt != MASK_END) begin
      r_mask_cnt <= r_mask_cnt + {{(MASK_CW-1){1'b0}}, 1'b1};
    end else begin
      r_mask_cnt <= r_mask_cnt;
    end
  end

  // Gate events by the startup mask and encode the winner.
  always_comb begin
    w_evt = 12'd0;
    if (r_mask_cnt == MASK_END) begin
      w_evt = w_evt_raw;
    end else begin
      w_evt = 12'd0;
    end
    w_any   = |w_evt;
    w_code  = lowest_code(w_evt);
    w_multi = is_multi(w_evt);
  end

  // Single-entry holding register FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      act_valid <= 1'b0;
      act_code  <= CODE_NONE;
      act_multi <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state   <= ST_PRESENT;
            act_valid <= 1'b1;
            act_code  <= w_code;
            act_multi <= w_multi;
          end else begin
            act_valid <= 1'b0;
            act_code  <= CODE_NONE;
            act_multi <= 1'b0;
          end
        end
        ST_PRESENT: begin
          if (act_ready) begin
            if (w_any) begin
              act_code  <= w_code;
              act_multi <= w_multi;
            end else begin
              r_state   <= ST_IDLE;
              act_valid <= 1'b0;
              act_code  <= CODE_NONE;
              act_multi <= 1'b0;
            end
          end else if (w_any) begin
            overrun <= 1'b1;
          end else begin
            overrun <= overrun;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          act_valid <= 1'b0;
          act_code  <= CODE_NONE;
          act_multi <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bop_input_encoder.sv
// Randomised + directed bench for bop_input_encoder against a behavioural model (DEBOUNCE_CYCLES=4).
module tb_bop_input_encoder;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw = 8'd0;
  logic       btnU = 1'b0, btnR = 1'b0, btnD = 1'b0, btnL = 1'b0;
  logic       act_ready = 1'b0;
  logic       act_valid, act_multi, overrun;
  logic [3:0] act_code;
  logic [7:0] sw_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bop_input_encoder #(.DEBOUNCE_CYCLES(DC), .NUM_SW(8)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btnU(btnU), .btnR(btnR), .btnD(btnD), .btnL(btnL),
    .act_valid(act_valid), .act_code(act_code), .act_multi(act_multi),
    .act_ready(act_ready), .overrun(overrun), .sw_level(sw_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: synced input = raw two samples ago; level flips after DC
  // consecutive synced samples disagreeing with it; one action register.
  logic [11:0] raw;
  assign raw = {btnL, btnD, btnR, btnU, sw};

  bit [11:0] m_p1, m_p2, m_stable, m_pulse, m_ev;
  bit [11:0] m_win [DC];
  bit        m_valid, m_multi, m_over, chk_en, m_all;
  int        m_code, m_since, m_n, m_first;
  bit [11:0] m_synced;

  always @(posedge clk) begin
    if (rst) begin
      m_p1 = 12'd0; m_p2 = 12'd0; m_stable = 12'd0; m_pulse = 12'd0;
      for (int i = 0; i < DC; i++) m_win[i] = 12'd0;
      m_valid = 1'b0; m_multi = 1'b0; m_over = 1'b0; m_code = 15; m_since = 0;
      chk_en = 1'b1;
    end else begin
      m_ev = (m_since >= DC + 3) ? m_pulse : 12'd0;
      m_n = $countones(m_ev);
      m_first = 15;
      for (int b = 11; b >= 0; b--) if (m_ev[b]) m_first = b;
      if (m_valid && act_ready) begin
        if (m_n > 0) begin m_code = m_first; m_multi = (m_n > 1); end
        else begin m_valid = 1'b0; m_code = 15; m_multi = 1'b0; end
      end else if (m_valid) begin
        if (m_n > 0) m_over = 1'b1;
      end else if (m_n > 0) begin
        m_valid = 1'b1; m_code = m_first; m_multi = (m_n > 1);
      end
      m_synced = m_p2; m_p2 = m_p1; m_p1 = raw;
      for (int i = DC - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = m_synced;
      m_pulse = 12'd0;
      for (int b = 0; b < 12; b++) begin
        m_all = 1'b1;
        for (int i = 0; i < DC; i++) if (m_win[i][b] == m_stable[b]) m_all = 1'b0;
        if (m_all) begin
          m_stable[b] = ~m_stable[b];
          if (m_stable[b]) m_pulse[b] = 1'b1;
`ifdef BOP_SW_BOTH_EDGES_EN
          else if (b < 8) m_pulse[b] = 1'b1;
`endif
        end
      end
      if (m_since < 1000) m_since++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", act_valid, m_valid);
      check("code", act_code, m_code);
      check("multi", act_multi, m_multi);
      check("overrun", overrun, m_over);
      check("sw_level", sw_level, m_stable[7:0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    check("rst_valid", act_valid, 0);
    check("rst_code", act_code, 15);
    check("rst_over", overrun, 0);
    check("rst_swlvl", sw_level, 0);
    sw[2] = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(12);
    check("sw2_level", sw_level[2], 1);
    check("sw2_noevt", act_valid, 0);
    cyc(20);

    // single press, immediate accept
    act_ready = 1'b1; btnR = 1'b1;
    cyc(6);
    check("r_early", act_valid, 0);
    cyc(1);
    check("r_valid", act_valid, 1);
    check("r_code", act_code, 9);
    check("r_multi", act_multi, 0);
    cyc(1);
    check("r_drop", act_valid, 0);
    check("r_none", act_code, 15);
    btnR = 1'b0;
    cyc(10);

    // simultaneous events
    act_ready = 1'b0; sw[5] = 1'b1; btnU = 1'b1;
    cyc(7);
    check("m_code", act_code, 5);
    check("m_multi", act_multi, 1);
    cyc(5);
    check("m_hold", act_valid, 1);
    act_ready = 1'b1;
    cyc(1);
    check("m_acc", act_valid, 0);
    check("m_none", act_code, 15);
    sw[5] = 1'b0; btnU = 1'b0;
    cyc(10);

    // glitches then held press
    act_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      btnD = 1'b1; cyc(1); btnD = 1'b0; cyc(1);
    end
    btnD = 1'b1;
    cyc(12);
    check("d_code", act_code, 10);
    check("d_multi", act_multi, 0);
    act_ready = 1'b1;
    cyc(12);
    check("d_held", act_valid, 0);

    // overrun
    act_ready = 1'b0; btnR = 1'b1;
    cyc(9);
    check("o_first", act_code, 9);
    btnL = 1'b1;
    cyc(9);
    check("o_over", overrun, 1);
    check("o_keep", act_code, 9);
    act_ready = 1'b1;
    cyc(1);
    act_ready = 1'b0; btnU = 1'b1;
    cyc(9);
    check("o_next", act_code, 8);
    check("o_sticky", overrun, 1);
    act_ready = 1'b1;
    cyc(1);

    // switch fall
    act_ready = 1'b0; sw[2] = 1'b0;
    cyc(9);
`ifdef BOP_SW_BOTH_EDGES_EN
    check("f_code", act_code, 2);
`else
    check("f_none", act_valid, 0);
`endif
    act_ready = 1'b1;
    cyc(1);

    // reset while presenting
    btnR = 1'b0; btnL = 1'b0; btnU = 1'b0; btnD = 1'b0;
    cyc(10);
    act_ready = 1'b0; sw[0] = 1'b1;
    cyc(9);
    check("x_pres", act_code, 0);
    rst = 1'b1;
    cyc(1);
    check("x_valid", act_valid, 0);
    check("x_code", act_code, 15);
    rst = 1'b0;
    cyc(15);
    check("x_quiet", act_valid, 0);

    // randomised phase
    for (int c = 0; c < 4000; c++) begin
      act_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 5) == 0) begin
        logic [11:0] r;
        r = raw;
        r[$urandom_range(0, 11)] ^= 1'b1;
        {btnL, btnD, btnR, btnU, sw} = r;
      end
      rst = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
